// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolution slice: RV32I branch funct3 encodings
// and the request/result record layouts used around the resolve stage.
package rv32i_types;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

endpackage

package br_types;
  import rv32i_types::*;

  // Canonical RV32 datapath width for the package-level records.
  localparam int unsigned BR_WIDTH = 32;
  // Fall-through distance for a non-compressed branch.
  localparam int unsigned PC_STEP  = 4;

  typedef struct packed {
    branch_funct3_t      cmpop;
    logic [BR_WIDTH-1:0] a;
    logic [BR_WIDTH-1:0] b;
    logic [BR_WIDTH-1:0] pc;
    logic [BR_WIDTH-1:0] offset;
    logic                pred_taken;
    logic [BR_WIDTH-1:0] pred_target;
  } br_req_t;

  typedef struct packed {
    logic                taken;
    logic [BR_WIDTH-1:0] target;
    logic [BR_WIDTH-1:0] next_pc;
    logic                mispredict;
    logic                illegal;
    logic [BR_WIDTH-1:0] pc;
  } br_res_t;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Combinational branch condition evaluator: decides taken/illegal from funct3.
module br_cond_eval
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       cmpop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             taken,
  output logic             illegal
);

  // Decode funct3; the two reserved encodings report illegal and not-taken.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (cmpop)
      BR_BEQ:  taken = (a == b);
      BR_BNE:  taken = (a != b);
      BR_BLT:  taken = ($signed(a) <  $signed(b));
      BR_BGE:  taken = ($signed(a) >= $signed(b));
      BR_BLTU: taken = (a <  b);
      BR_BGEU: taken = (a >= b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolution stage: evaluates the branch, computes target and
// next PC, flags mispredictions, and keeps saturating retirement counters.
module branch_resolve_unit
  import br_types::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PIPE  = 1,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_cmpop,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_offset,
  input  logic             in_pred_taken,
  input  logic [WIDTH-1:0] in_pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [WIDTH-1:0] out_target,
  output logic [WIDTH-1:0] out_next_pc,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [WIDTH-1:0] out_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  // Width-specific views of the br_types records.
  typedef struct packed {
    logic [2:0]       cmpop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] offset;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;
  } req_t;

  typedef struct packed {
    logic             taken;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] next_pc;
    logic             mispredict;
    logic             illegal;
    logic [WIDTH-1:0] pc;
  } res_t;

  req_t             in_req;
  req_t             src_req;
  logic             src_valid;
  logic             fin_ready;
  logic             retire;
  logic             out_valid_q, out_valid_d;
  res_t             res_q, res_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic             ev_taken, ev_illegal;
  logic [WIDTH-1:0] tgt;

  // Pack the request ports into one record.
  always_comb begin
    in_req.cmpop       = in_cmpop;
    in_req.a           = in_a;
    in_req.b           = in_b;
    in_req.pc          = in_pc;
    in_req.offset      = in_offset;
    in_req.pred_taken  = in_pred_taken;
    in_req.pred_target = in_pred_target;
  end

  // Output stage can take a new entry when empty or draining this cycle.
  always_comb fin_ready = !out_valid_q || out_ready;

  generate
    if (PIPE != 0) begin : g_opreg
      logic op_valid_q, op_valid_d;
      req_t op_req_q, op_req_d;
      logic op_ready;

      // Operand stage handshake: free slot or its entry moves on this cycle.
      always_comb op_ready = !op_valid_q || fin_ready;

      // Operand stage next state: capture accepted request, drop on flush.
      always_comb begin
        op_valid_d = op_valid_q;
        op_req_d   = op_req_q;
        if (flush) begin
          op_valid_d = 1'b0;
        end else if (op_ready) begin
          op_valid_d = in_valid;
          if (in_valid) op_req_d = in_req;
        end
      end

      // Operand stage registers.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          op_valid_q <= 1'b0;
          op_req_q   <= '0;
        end else begin
          op_valid_q <= op_valid_d;
          op_req_q   <= op_req_d;
        end
      end

      assign in_ready  = op_ready && !flush;
      assign src_valid = op_valid_q;
      assign src_req   = op_req_q;
    end else begin : g_direct
      assign in_ready  = fin_ready && !flush;
      assign src_valid = in_valid && in_ready;
      assign src_req   = in_req;
    end
  endgenerate

  br_cond_eval #(.WIDTH(WIDTH)) u_cond (
    .cmpop   (src_req.cmpop),
    .a       (src_req.a),
    .b       (src_req.b),
    .taken   (ev_taken),
    .illegal (ev_illegal)
  );

  // Result stage next state: resolve the branch and load it when there is room.
  always_comb begin
    tgt         = src_req.pc + src_req.offset;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fin_ready) begin
      out_valid_d = src_valid;
      if (src_valid) begin
        res_d.taken   = ev_taken;
        res_d.illegal = ev_illegal;
        res_d.target  = tgt;
        res_d.next_pc = ev_taken ? tgt : src_req.pc + WIDTH'(PC_STEP);
        res_d.pc      = src_req.pc;
        // Illegal ops are never taken, so only the predicted direction matters.
        if (ev_illegal)
          res_d.mispredict = src_req.pred_taken;
        else
          res_d.mispredict = (ev_taken != src_req.pred_taken) ||
                             (ev_taken && (src_req.pred_target != tgt));
      end
    end
  end

  // Retirement counters saturate at all-ones; flush never touches them.
  always_comb begin
    retire    = out_valid_q && out_ready;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (retire) begin
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (res_q.mispredict && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  // Result stage and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_taken      = res_q.taken;
  assign out_target     = res_q.target;
  assign out_next_pc    = res_q.next_pc;
  assign out_mispredict = res_q.mispredict;
  assign out_illegal    = res_q.illegal;
  assign out_pc         = res_q.pc;
  assign br_cnt         = br_cnt_q;
  assign mispred_cnt    = mis_cnt_q;

endmodule
